// File: rtl/rv_mem_arb_pkg.sv
// Shared constants, FSM state type and helpers for the memory arbiter.
// Imported by rv_mem_arb and rv_arb_cnt.
package rv_mem_arb_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned WAIT_CYC_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CORE_ACC,
        ST_DMA_ACC,
        ST_DONE
    } arb_state_e;

    // Counter preload: counting down to zero gives cyc access cycles.
    function automatic logic [CNT_W-1:0] cnt_init(input int unsigned cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/rv_arb_cnt.sv
// Loadable down-counter with zero flag that times a memory access.
// Ports: clk, rst, i_load/i_val (preload), i_dec (count), o_zero.
module rv_arb_cnt
    import rv_mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rv_mem_arb.sv
// Two-port (core, DMA) round-robin arbiter onto one multi-cycle memory.
// Ports: core_* and dma_* request/grant ports, mem_* memory side.
module rv_mem_arb
    import rv_mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_gnt,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [XLEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    output logic [XLEN-1:0] dma_rdata,
    output logic            dma_gnt,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    arb_state_e      r_state;
    logic            r_last_dma;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_core_rdata;
    logic [XLEN-1:0] r_dma_rdata;
    logic            r_mem_en;
    logic            r_mem_we;
    logic            r_core_gnt;
    logic            r_dma_gnt;

    logic            w_acc;
    logic            w_load;
    logic            w_zero;
    logic            w_pick_dma;

    assign w_acc  = (r_state == ST_CORE_ACC) || (r_state == ST_DMA_ACC);
    assign w_load = (r_state == ST_IDLE) && (core_req || dma_req);

    // On a tie the port that was not served last wins.
    assign w_pick_dma = dma_req && (!core_req || !r_last_dma);

    rv_arb_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_dec  (w_acc),
        .i_val  (cnt_init(WAIT_CYC)),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_dma   <= 1'b1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_core_gnt   <= 1'b0;
            r_dma_gnt    <= 1'b0;
        end else begin
            r_core_gnt <= 1'b0;
            r_dma_gnt  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_last_dma <= w_pick_dma;
                        r_we       <= w_pick_dma ? dma_we    : core_we;
                        r_addr     <= w_pick_dma ? dma_addr  : core_addr;
                        r_wdata    <= w_pick_dma ? dma_wdata : core_wdata;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick_dma ? dma_we    : core_we;
                        r_state    <= w_pick_dma ? ST_DMA_ACC : ST_CORE_ACC;
                    end
                end
                ST_CORE_ACC, ST_DMA_ACC: begin
                    if (w_zero) begin
                        // Read data is only valid on the last access cycle.
                        if (!r_we) begin
                            if (r_state == ST_DMA_ACC) begin
                                r_dma_rdata <= mem_rdata;
                            end else begin
                                r_core_rdata <= mem_rdata;
                            end
                        end
                        r_core_gnt <= (r_state == ST_CORE_ACC);
                        r_dma_gnt  <= (r_state == ST_DMA_ACC);
                        r_mem_en   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign core_rdata = r_core_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign core_gnt   = r_core_gnt;
    assign dma_gnt    = r_dma_gnt;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboard bench for rv_mem_arb: directed cases, then random traffic.
// Includes WAIT_CYC=1 and WAIT_CYC=15 instances for latency limits.
module tb_rv_mem_arb;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        core_req, core_we, core_gnt;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_gnt;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    rv_mem_arb #(.WAIT_CYC(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_gnt   (core_gnt),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_rdata  (dma_rdata),
        .dma_gnt    (dma_gnt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory model: data is only valid on the W-th access cycle.
    int en_run;
    always @(posedge clk or posedge rst) begin
        if (rst) en_run <= 0;
        else     en_run <= mem_en ? en_run + 1 : 0;
    end
    assign mem_rdata = (mem_en && en_run == W - 1) ? memf(mem_addr)
                                                    : 32'hBAD0BAD0;

    // Extra instances: index 0 has WAIT_CYC=1, index 1 has WAIT_CYC=15.
    logic        xc_req[2], xc_we[2], xc_gnt[2];
    logic [31:0] xc_addr[2], xc_wdata[2], xc_rdata[2];
    logic        xd_req[2], xd_we[2], xd_gnt[2];
    logic [31:0] xd_addr[2], xd_wdata[2], xd_rdata[2];
    logic        xm_en[2], xm_we[2];
    logic [31:0] xm_addr[2], xm_wdata[2], xm_rdata[2];

    for (genvar g = 0; g < 2; g++) begin : g_x
        rv_mem_arb #(.WAIT_CYC(g == 0 ? 1 : 15)) u_x (
            .clk        (clk),
            .rst        (rst),
            .core_req   (xc_req[g]),
            .core_we    (xc_we[g]),
            .core_addr  (xc_addr[g]),
            .core_wdata (xc_wdata[g]),
            .core_rdata (xc_rdata[g]),
            .core_gnt   (xc_gnt[g]),
            .dma_req    (xd_req[g]),
            .dma_we     (xd_we[g]),
            .dma_addr   (xd_addr[g]),
            .dma_wdata  (xd_wdata[g]),
            .dma_rdata  (xd_rdata[g]),
            .dma_gnt    (xd_gnt[g]),
            .mem_en     (xm_en[g]),
            .mem_we     (xm_we[g]),
            .mem_addr   (xm_addr[g]),
            .mem_wdata  (xm_wdata[g]),
            .mem_rdata  (xm_rdata[g])
        );
        assign xm_rdata[g] = memf(xm_addr[g]);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: transaction level, one record per transfer.
    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          start;
        int          gnt_edge;
    } tr_t;

    typedef struct {
        int port;
        int ed;
    } g_t;

    tr_t         q[$];
    g_t          glog[$];
    tr_t         cur, nt, pt;
    bit          cur_valid;
    int          edge_n;
    int          free_at;
    bit          last_dma;
    logic [31:0] rd_m[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n    = 0;
            free_at   = 0;
            last_dma  = 1'b1;
            cur_valid = 1'b0;
            q.delete();
            rd_m[0]   = '0;
            rd_m[1]   = '0;
        end else begin
            edge_n++;
            if (edge_n >= free_at && (core_req || dma_req)) begin
                if (core_req && !dma_req)      nt.port = 0;
                else if (dma_req && !core_req) nt.port = 1;
                else                           nt.port = last_dma ? 0 : 1;
                last_dma = (nt.port == 1);
                nt.we    = nt.port == 1 ? dma_we    : core_we;
                nt.addr  = nt.port == 1 ? dma_addr  : core_addr;
                nt.wdata = nt.port == 1 ? dma_wdata : core_wdata;
                nt.rdata = memf(nt.addr);
                nt.start    = edge_n;
                nt.gnt_edge = edge_n + W;
                free_at     = edge_n + W + 2;
                cur         = nt;
                cur_valid   = 1'b1;
                q.push_back(nt);
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard on each grant.
    int en_cnt = 0;
    int we_cnt = 0;
    bit m_en, m_gc, m_gd;

    always @(negedge clk) begin
        if (!rst) begin
            m_en = cur_valid && edge_n >= cur.start
                   && edge_n < cur.start + W;
            m_gc = cur_valid && edge_n == cur.gnt_edge && cur.port == 0;
            m_gd = cur_valid && edge_n == cur.gnt_edge && cur.port == 1;
            chk("mem_en", mem_en, m_en);
            chk("mem_we", mem_we, m_en & cur.we);
            chk("we_wo_en", mem_we & ~mem_en, 0);
            if (m_en) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_wdata", mem_wdata, cur.wdata);
            end
            chk("core_gnt", core_gnt, m_gc);
            chk("dma_gnt", dma_gnt, m_gd);
            if (mem_en) en_cnt++;
            if (mem_en && mem_we) we_cnt++;
            if (core_gnt || dma_gnt) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got grant want none");
                end else begin
                    pt = q.pop_front();
                    chk("gnt_port", core_gnt ? 0 : 1, pt.port);
                    if (!pt.we) rd_m[pt.port] = pt.rdata;
                end
                glog.push_back('{core_gnt ? 0 : 1, edge_n});
            end
            chk("core_rdata", core_rdata, rd_m[0]);
            chk("dma_rdata", dma_rdata, rd_m[1]);
        end
    end

    int xen_cnt[2] = '{0, 0};
    always @(negedge clk) begin
        if (!rst) begin
            for (int g = 0; g < 2; g++) begin
                chk("x_we_wo_en", xm_we[g] & ~xm_en[g], 0);
                if (xm_en[g]) xen_cnt[g]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int n);
        for (int i = 0; i < 60 && glog.size() < n; i++) tick();
        total++;
        if (glog.size() < n) begin
            bad++;
            $display("FAIL gnt_timeout: got %0d grants want %0d",
                     glog.size(), n);
        end
    endtask

    task automatic raise(input int p);
        logic [31:0] a;
        a = ($urandom_range(0, 7) == 0) ? 32'h100
                                        : ($urandom & 32'hFFFFFFFC);
        if (p == 0) begin
            core_req   = 1'b1;
            core_we    = 1'($urandom_range(0, 1));
            core_addr  = a;
            core_wdata = $urandom;
        end else begin
            dma_req    = 1'b1;
            dma_we     = 1'($urandom_range(0, 1));
            dma_addr   = a;
            dma_wdata  = $urandom;
        end
    endtask

    // Drop the request; scramble the other fields to prove they are latched.
    task automatic drop(input int p, input bit scr);
        if (p == 0) begin
            core_req = 1'b0;
            if (scr) begin
                core_we    = ~core_we;
                core_addr  = $urandom;
                core_wdata = $urandom;
            end
        end else begin
            dma_req = 1'b0;
            if (scr) begin
                dma_we    = ~dma_we;
                dma_addr  = $urandom;
                dma_wdata = $urandom;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gp, rq;
        bit   infl;
        int   n, e0, w0;
        int   gk[2];

        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        dma_req  = 0; dma_we  = 0; dma_addr  = 0; dma_wdata  = 0;
        for (int g = 0; g < 2; g++) begin
            xc_req[g] = 0; xc_we[g] = 0; xc_addr[g] = 0; xc_wdata[g] = 0;
            xd_req[g] = 0; xd_we[g] = 0; xd_addr[g] = 0; xd_wdata[g] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);

        // Both ports request out of reset and hold for four transfers.
        core_req = 1; core_we = 0; core_addr = 32'h100;
        dma_req  = 1; dma_we  = 0; dma_addr  = 32'h300;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_en", mem_en, 0);
        wait_gnts(4);
        core_req = 0;
        dma_req  = 0;
        if (glog.size() >= 4) begin
            chk("first_gnt_cyc", glog[0].ed, 3);
            chk("order0", glog[0].port, 0);
            chk("order1", glog[1].port, 1);
            chk("order2", glog[2].port, 0);
            chk("order3", glog[3].port, 1);
            chk("gap1", glog[1].ed - glog[0].ed, 4);
            chk("gap2", glog[2].ed - glog[1].ed, 4);
            chk("gap3", glog[3].ed - glog[2].ed, 4);
        end
        chk("core_beef", core_rdata, 32'hDEADBEEF);

        // DMA write.
        tick();
        n  = glog.size();
        w0 = we_cnt;
        dma_req = 1; dma_we = 1;
        dma_addr = 32'h200; dma_wdata = 32'h12345678;
        wait_gnts(n + 1);
        dma_req = 0;
        chk("dma_wr_we_cyc", we_cnt - w0, 2);
        chk("dma_wr_core_rd", core_rdata, 32'hDEADBEEF);
        chk("dma_wr_port", glog[glog.size() - 1].port, 1);

        // Core drops its request in the first access cycle.
        tick();
        n  = glog.size();
        e0 = en_cnt;
        core_req = 1; core_we = 0; core_addr = 32'h440;
        for (int i = 0; i < 10 && !mem_en; i++) tick();
        drop(0, 1'b1);
        wait_gnts(n + 1);
        repeat (6) tick();
        chk("drop_gnt_cnt", glog.size(), n + 1);
        chk("drop_en_cyc", en_cnt - e0, 2);

        // Reset in the first access cycle aborts the transfer.
        n = glog.size();
        core_req = 1; core_we = 0; core_addr = 32'h100;
        for (int i = 0; i < 10 && !mem_en; i++) tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_en", mem_en, 0);
        chk("abort_mem_we", mem_we, 0);
        chk("abort_core_gnt", core_gnt, 0);
        core_req = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) tick();
        chk("abort_no_gnt", glog.size(), n);
        chk("abort_rdata", core_rdata, 0);
        core_req = 1; core_we = 0; core_addr = 32'h540;
        dma_req  = 1; dma_we  = 0; dma_addr  = 32'h640;
        wait_gnts(n + 1);
        core_req = 0;
        dma_req  = 0;
        chk("abort_tie_core", glog[glog.size() - 1].port, 0);

        // Latency limits on the WAIT_CYC=1 and WAIT_CYC=15 instances.
        tick();
        gk[0] = 0;
        gk[1] = 0;
        for (int g = 0; g < 2; g++) begin
            xc_req[g] = 1; xc_we[g] = 0; xc_addr[g] = 32'h100;
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                if (xc_gnt[g] && gk[g] == 0) begin
                    gk[g]     = k;
                    xc_req[g] = 0;
                end
            end
        end
        chk("w1_gnt_cyc", gk[0], 2);
        chk("w15_gnt_cyc", gk[1], 16);
        chk("w1_en_cyc", xen_cnt[0], 1);
        chk("w15_en_cyc", xen_cnt[1], 15);
        chk("w1_rdata", xc_rdata[0], 32'hDEADBEEF);
        chk("w15_rdata", xc_rdata[1], 32'hDEADBEEF);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                gp   = (p == 0) ? core_gnt : dma_gnt;
                rq   = (p == 0) ? core_req : dma_req;
                infl = cur_valid && cur.port == p && edge_n <= cur.gnt_edge;
                if (gp) begin
                    drop(p, 1'b0);
                    if ($urandom_range(0, 1) == 1) raise(p);
                end else if (infl) begin
                    if ($urandom_range(0, 3) == 0) drop(p, 1'b1);
                end else if (!rq && $urandom_range(0, 2) == 0) begin
                    raise(p);
                end
            end
        end

        // Drain outstanding requests.
        for (int i = 0; i < 100; i++) begin
            tick();
            if (core_gnt) core_req = 0;
            if (dma_gnt)  dma_req  = 0;
            if (!core_req && !dma_req && q.size() == 0 && !mem_en) break;
        end
        chk("drain_sb", q.size(), 0);
        chk("drain_req", {core_req, dma_req}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
